// File: rtl/mcs51_pkg.sv
// Shared MCS-51 definitions used by the interrupt controller: SFR bit
// positions, interrupt vector addresses, source indices, the controller
// state enum and the index-to-vector lookup.
package mcs51_pkg;

    // IE SFR bit positions
    localparam int IE_EX0 = 0;
    localparam int IE_ET0 = 1;
    localparam int IE_EX1 = 2;
    localparam int IE_ET1 = 3;
    localparam int IE_ES  = 4;
    localparam int IE_EA  = 7;

    // IP SFR bit positions (bits 7:5 carry no meaning)
    localparam int IP_PX0 = 0;
    localparam int IP_PT0 = 1;
    localparam int IP_PX1 = 2;
    localparam int IP_PT1 = 3;
    localparam int IP_PS  = 4;

    // TCON SFR bit positions
    localparam int TCON_IT0 = 0;
    localparam int TCON_IE0 = 1;
    localparam int TCON_IT1 = 2;
    localparam int TCON_IE1 = 3;
    localparam int TCON_TR0 = 4;
    localparam int TCON_TF0 = 5;
    localparam int TCON_TR1 = 6;
    localparam int TCON_TF1 = 7;

    // Interrupt vector addresses
    localparam logic [15:0] VEC_INT0 = 16'h0003;
    localparam logic [15:0] VEC_T0   = 16'h000B;
    localparam logic [15:0] VEC_INT1 = 16'h0013;
    localparam logic [15:0] VEC_T1   = 16'h001B;
    localparam logic [15:0] VEC_SER  = 16'h0023;

    // Source index; numeric order is also the fixed priority order,
    // and matches the IE/IP bit positions of each source.
    typedef logic [2:0] src_idx_t;

    localparam src_idx_t SRC_INT0 = 3'd0;
    localparam src_idx_t SRC_T0   = 3'd1;
    localparam src_idx_t SRC_INT1 = 3'd2;
    localparam src_idx_t SRC_T1   = 3'd3;
    localparam src_idx_t SRC_SER  = 3'd4;

    // Interrupt controller states
    typedef enum logic [1:0] {
        INTC_IDLE = 2'd0,
        INTC_PEND = 2'd1,
        INTC_ACK  = 2'd2
    } intc_state_t;

    // Map a source index to its vector address
    function automatic logic [15:0] vec_lookup(input src_idx_t idx);
        logic [15:0] vec;
        case (idx)
            SRC_INT0: vec = VEC_INT0;
            SRC_T0:   vec = VEC_T0;
            SRC_INT1: vec = VEC_INT1;
            SRC_T1:   vec = VEC_T1;
            SRC_SER:  vec = VEC_SER;
            default:  vec = 16'h0000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/mcs51_intc_if.sv
// Handshake between the CPU core and the interrupt controller.
// The controller side is the slave; the core side is the master.
interface mcs51_intc_if;

    logic        int_poll;
    logic        irq_ack;
    logic        reti;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic [1:0]  in_svc;

    modport master (
        output int_poll,
        output irq_ack,
        output reti,
        input  irq_req,
        input  irq_vec,
        input  in_svc
    );

    modport slave (
        input  int_poll,
        input  irq_ack,
        input  reti,
        output irq_req,
        output irq_vec,
        output in_svc
    );

endinterface

// File: rtl/mcs51_intc_prio.sv
// Five-input fixed-priority encoder: bit 0 (INT0) wins over bit 4 (Serial).
module mcs51_intc_prio
    import mcs51_pkg::*;
(
    input  logic [4:0] req,
    output logic       valid,
    output src_idx_t   idx
);

    // Pick the lowest-numbered active request
    always_comb begin
        valid = |req;
        idx   = SRC_INT0;
        if (req[0])
            idx = SRC_INT0;
        else if (req[1])
            idx = SRC_T0;
        else if (req[2])
            idx = SRC_INT1;
        else if (req[3])
            idx = SRC_T1;
        else if (req[4])
            idx = SRC_SER;
    end

endmodule

// File: rtl/mcs51_intc.sv
// MCS-51 two-level interrupt controller. Arbitrates the five interrupt
// sources when the core polls, holds the request until the core acks or
// the winner is disabled, then pulses the winner's flag clear and tracks
// which priority levels are in service until RETI.
module mcs51_intc
    import mcs51_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mcs51_intc_if.slave core,
    input  logic [7:0] ie_reg,
    input  logic [7:0] ip_reg,
    input  logic [7:0] tcon,
    input  logic       scon_ri,
    input  logic       scon_ti,
    output logic       clr_ie0,
    output logic       clr_ie1,
    output logic       clr_tf0,
    output logic       clr_tf1
);

    intc_state_t state;
    src_idx_t    win_idx_q;
    logic        win_hi_q;
    logic        irq_req_q;
    logic [15:0] irq_vec_q;
    logic [1:0]  in_svc_q;
    logic        clr_ie0_q;
    logic        clr_ie1_q;
    logic        clr_tf0_q;
    logic        clr_tf1_q;

    logic [4:0]  src_flag;
    logic [4:0]  src_elig;
    logic [4:0]  hi_req;
    logic [4:0]  lo_req;
    logic        hi_valid;
    logic        lo_valid;
    src_idx_t    hi_idx;
    src_idx_t    lo_idx;
    logic        win_valid;
    src_idx_t    win_sel;
    logic        winner_enabled;
    logic [1:0]  in_svc_reti;
    logic        unused_sfr_bits;

    // Timer run bits, IE bits 6:5 and IP bits 7:5 play no part here
    assign unused_sfr_bits = ^{ip_reg[7:5], ie_reg[6:5], tcon[TCON_TR1], tcon[TCON_TR0]};

    // Source flags in priority order; IE and IP enable bits share this order
    assign src_flag = {scon_ri | scon_ti, tcon[TCON_TF1], tcon[TCON_IE1],
                       tcon[TCON_TF0], tcon[TCON_IE0]};
    assign src_elig = ie_reg[IE_EA] ? (src_flag & ie_reg[4:0]) : 5'b00000;

    // High level is blocked only by a high-level service; low level by any
    assign hi_req = src_elig &  ip_reg[4:0] & {5{~in_svc_q[1]}};
    assign lo_req = src_elig & ~ip_reg[4:0] & {5{in_svc_q == 2'b00}};

    mcs51_intc_prio u_prio_hi (
        .req   (hi_req),
        .valid (hi_valid),
        .idx   (hi_idx)
    );

    mcs51_intc_prio u_prio_lo (
        .req   (lo_req),
        .valid (lo_valid),
        .idx   (lo_idx)
    );

    assign win_valid      = hi_valid | lo_valid;
    assign win_sel        = hi_valid ? hi_idx : lo_idx;
    assign winner_enabled = ie_reg[IE_EA] & ie_reg[win_idx_q];

    // RETI retires the highest active level; applied before any ack set
    always_comb begin
        in_svc_reti = in_svc_q;
        if (core.reti) begin
            if (in_svc_q[1])
                in_svc_reti[1] = 1'b0;
            else
                in_svc_reti[0] = 1'b0;
        end
    end

    // Controller FSM with registered request, vector, clear pulses and service state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INTC_IDLE;
            win_idx_q <= SRC_INT0;
            win_hi_q  <= 1'b0;
            irq_req_q <= 1'b0;
            irq_vec_q <= 16'h0000;
            in_svc_q  <= 2'b00;
            clr_ie0_q <= 1'b0;
            clr_ie1_q <= 1'b0;
            clr_tf0_q <= 1'b0;
            clr_tf1_q <= 1'b0;
        end else begin
            clr_ie0_q <= 1'b0;
            clr_ie1_q <= 1'b0;
            clr_tf0_q <= 1'b0;
            clr_tf1_q <= 1'b0;
            in_svc_q  <= in_svc_reti;
            case (state)
                INTC_IDLE: begin
                    if (core.int_poll && win_valid) begin
                        state     <= INTC_PEND;
                        win_idx_q <= win_sel;
                        win_hi_q  <= hi_valid;
                        irq_req_q <= 1'b1;
                        irq_vec_q <= vec_lookup(win_sel);
                    end
                end
                INTC_PEND: begin
                    if (core.irq_ack) begin
                        state     <= INTC_ACK;
                        irq_req_q <= 1'b0;
                        irq_vec_q <= 16'h0000;
                        in_svc_q  <= in_svc_reti | (win_hi_q ? 2'b10 : 2'b01);
                        case (win_idx_q)
                            SRC_INT0: clr_ie0_q <= tcon[TCON_IT0];
                            SRC_T0:   clr_tf0_q <= 1'b1;
                            SRC_INT1: clr_ie1_q <= tcon[TCON_IT1];
                            SRC_T1:   clr_tf1_q <= 1'b1;
                            default:  ;
                        endcase
                    end else if (!winner_enabled) begin
                        state     <= INTC_IDLE;
                        irq_req_q <= 1'b0;
                        irq_vec_q <= 16'h0000;
                    end
                end
                INTC_ACK: begin
                    state <= INTC_IDLE;
                end
                default: begin
                    state     <= INTC_IDLE;
                    irq_req_q <= 1'b0;
                    irq_vec_q <= 16'h0000;
                end
            endcase
        end
    end

    assign core.irq_req = irq_req_q;
    assign core.irq_vec = irq_vec_q;
    assign core.in_svc  = in_svc_q;
    assign clr_ie0      = clr_ie0_q;
    assign clr_ie1      = clr_ie1_q;
    assign clr_tf0      = clr_tf0_q;
    assign clr_tf1      = clr_tf1_q;

endmodule

// File: tb/tb_mcs51_intc.sv
// Directed self-checking bench for the MCS-51 interrupt controller.
module tb_mcs51_intc;

    logic       clk;
    logic       rst;
    logic [7:0] ie_reg;
    logic [7:0] ip_reg;
    logic [7:0] tcon;
    logic       scon_ri;
    logic       scon_ti;
    logic       clr_ie0;
    logic       clr_ie1;
    logic       clr_tf0;
    logic       clr_tf1;

    int vectors_applied = 0;
    int miscompares     = 0;

    mcs51_intc_if core_if ();

    mcs51_intc dut (
        .clk     (clk),
        .rst     (rst),
        .core    (core_if),
        .ie_reg  (ie_reg),
        .ip_reg  (ip_reg),
        .tcon    (tcon),
        .scon_ri (scon_ri),
        .scon_ti (scon_ti),
        .clr_ie0 (clr_ie0),
        .clr_ie1 (clr_ie1),
        .clr_tf0 (clr_tf0),
        .clr_tf1 (clr_tf1)
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // One comparison against a hand-computed value
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors_applied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] clr_bits();
        return {12'h000, clr_ie0, clr_ie1, clr_tf0, clr_tf1};
    endfunction

    // Directed sequence
    initial begin
        rst              = 1'b1;
        ie_reg           = 8'h00;
        ip_reg           = 8'h00;
        tcon             = 8'h00;
        scon_ri          = 1'b0;
        scon_ti          = 1'b0;
        core_if.int_poll = 1'b0;
        core_if.irq_ack  = 1'b0;
        core_if.reti     = 1'b0;

        applyStimulus();
        applyStimulus();
        checkOutput("rst_req", {15'h0, core_if.irq_req}, 16'h0000);
        checkOutput("rst_vec", core_if.irq_vec, 16'h0000);
        checkOutput("rst_svc", {14'h0, core_if.in_svc}, 16'h0000);
        checkOutput("rst_clr", clr_bits(), 16'h0000);
        rst = 1'b0;

        // Edge INT0: flag pending without poll must not request
        ie_reg = 8'h81;
        tcon   = 8'h03;
        applyStimulus();
        applyStimulus();
        checkOutput("nopoll_req", {15'h0, core_if.irq_req}, 16'h0000);
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("int0_req", {15'h0, core_if.irq_req}, 16'h0001);
        checkOutput("int0_vec", core_if.irq_vec, 16'h0003);
        core_if.irq_ack = 1'b1;
        applyStimulus();
        core_if.irq_ack = 1'b0;
        checkOutput("int0_clr", clr_bits(), 16'h0008);
        checkOutput("int0_svc", {14'h0, core_if.in_svc}, 16'h0001);
        checkOutput("int0_ack_req", {15'h0, core_if.irq_req}, 16'h0000);
        checkOutput("int0_ack_vec", core_if.irq_vec, 16'h0000);
        tcon = 8'h01;
        applyStimulus();
        checkOutput("int0_clr_end", clr_bits(), 16'h0000);
        core_if.reti = 1'b1;
        applyStimulus();
        core_if.reti = 1'b0;
        checkOutput("int0_reti", {14'h0, core_if.in_svc}, 16'h0000);

        // High-priority T1 beats low-priority INT0
        ie_reg = 8'h9F;
        ip_reg = 8'h08;
        tcon   = 8'h82;
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("t1hi_vec", core_if.irq_vec, 16'h001B);
        core_if.irq_ack = 1'b1;
        applyStimulus();
        core_if.irq_ack = 1'b0;
        checkOutput("t1hi_clr", clr_bits(), 16'h0001);
        checkOutput("t1hi_svc", {14'h0, core_if.in_svc}, 16'h0002);
        tcon = 8'h00;
        applyStimulus();
        core_if.reti = 1'b1;
        applyStimulus();
        core_if.reti = 1'b0;
        checkOutput("t1hi_reti", {14'h0, core_if.in_svc}, 16'h0000);

        // Low T0 in service, then low T1 blocked, high INT1 nests
        ip_reg = 8'h00;
        tcon   = 8'h20;
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("t0_vec", core_if.irq_vec, 16'h000B);
        core_if.irq_ack = 1'b1;
        applyStimulus();
        core_if.irq_ack = 1'b0;
        checkOutput("t0_clr", clr_bits(), 16'h0002);
        checkOutput("t0_svc", {14'h0, core_if.in_svc}, 16'h0001);
        tcon = 8'h80;
        applyStimulus();
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("t1lo_blocked", {15'h0, core_if.irq_req}, 16'h0000);
        tcon   = 8'h08;
        ip_reg = 8'h04;
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("int1hi_req", {15'h0, core_if.irq_req}, 16'h0001);
        checkOutput("int1hi_vec", core_if.irq_vec, 16'h0013);
        core_if.irq_ack = 1'b1;
        applyStimulus();
        core_if.irq_ack = 1'b0;
        checkOutput("int1hi_clr", clr_bits(), 16'h0000);
        checkOutput("int1hi_svc", {14'h0, core_if.in_svc}, 16'h0003);
        tcon   = 8'h80;
        ip_reg = 8'h08;
        applyStimulus();
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("svc11_blocked", {15'h0, core_if.irq_req}, 16'h0000);
        tcon   = 8'h00;
        ip_reg = 8'h00;
        core_if.reti = 1'b1;
        applyStimulus();
        checkOutput("reti_11_01", {14'h0, core_if.in_svc}, 16'h0001);
        applyStimulus();
        checkOutput("reti_01_00", {14'h0, core_if.in_svc}, 16'h0000);
        applyStimulus();
        core_if.reti = 1'b0;
        checkOutput("reti_00_00", {14'h0, core_if.in_svc}, 16'h0000);

        // Level-triggered INT0 is not cleared
        ie_reg = 8'h81;
        tcon   = 8'h02;
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("lvl_vec", core_if.irq_vec, 16'h0003);
        core_if.irq_ack = 1'b1;
        applyStimulus();
        core_if.irq_ack = 1'b0;
        checkOutput("lvl_clr", clr_bits(), 16'h0000);
        checkOutput("lvl_svc", {14'h0, core_if.in_svc}, 16'h0001);
        tcon = 8'h00;
        applyStimulus();
        core_if.reti = 1'b1;
        applyStimulus();
        core_if.reti = 1'b0;

        // Serial RI: vector 0x0023, no clear pulses
        ie_reg  = 8'h90;
        scon_ri = 1'b1;
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("ser_vec", core_if.irq_vec, 16'h0023);
        core_if.irq_ack = 1'b1;
        applyStimulus();
        core_if.irq_ack = 1'b0;
        checkOutput("ser_clr", clr_bits(), 16'h0000);
        checkOutput("ser_svc", {14'h0, core_if.in_svc}, 16'h0001);
        scon_ri = 1'b0;
        applyStimulus();
        core_if.reti = 1'b1;
        applyStimulus();
        core_if.reti = 1'b0;
        checkOutput("ser_reti", {14'h0, core_if.in_svc}, 16'h0000);

        // Winner frozen in PEND, then withdrawn by clearing EA
        ie_reg = 8'h82;
        tcon   = 8'h20;
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("pend_vec", core_if.irq_vec, 16'h000B);
        ie_reg = 8'h83;
        ip_reg = 8'hFF;
        tcon   = 8'h22;
        applyStimulus();
        checkOutput("frozen_vec", core_if.irq_vec, 16'h000B);
        ie_reg = 8'h02;
        applyStimulus();
        checkOutput("wd_req", {15'h0, core_if.irq_req}, 16'h0000);
        checkOutput("wd_vec", core_if.irq_vec, 16'h0000);
        checkOutput("wd_svc", {14'h0, core_if.in_svc}, 16'h0000);
        core_if.irq_ack = 1'b1;
        applyStimulus();
        core_if.irq_ack = 1'b0;
        checkOutput("stray_ack_svc", {14'h0, core_if.in_svc}, 16'h0000);
        checkOutput("stray_ack_clr", clr_bits(), 16'h0000);
        ip_reg = 8'h00;

        // Asynchronous reset in PEND aborts without a clear pulse
        ie_reg = 8'h82;
        tcon   = 8'h20;
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("pre_rst_req", {15'h0, core_if.irq_req}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_req", {15'h0, core_if.irq_req}, 16'h0000);
        checkOutput("async_rst_vec", core_if.irq_vec, 16'h0000);
        checkOutput("async_rst_svc", {14'h0, core_if.in_svc}, 16'h0000);
        core_if.irq_ack = 1'b1;
        applyStimulus();
        core_if.irq_ack = 1'b0;
        checkOutput("rst_ack_clr", clr_bits(), 16'h0000);
        rst = 1'b0;
        applyStimulus();
        checkOutput("post_rst_nopoll", {15'h0, core_if.irq_req}, 16'h0000);
        core_if.int_poll = 1'b1;
        applyStimulus();
        core_if.int_poll = 1'b0;
        checkOutput("post_rst_vec", core_if.irq_vec, 16'h000B);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
